// File: rtl/bp_table_ctrl.sv
// Pattern-table controller for the 2-bit branch predictor: power-up init sweep,
// then single-port arbitration between decoder lookups and FIFO-buffered training updates.
module bp_table_ctrl #(
    parameter int unsigned INDEX_BITS = 7,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [1:0]  INIT_STATE = 2'b01,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  dec_req_in,
    input  logic [ADDR_WIDTH-1:0] dec_pc_in,
    output logic                  dec_ready_out,
    output logic                  pred_valid_out,
    output logic                  pred_taken_out,
    input  logic                  rob_train_en_in,
    input  logic [ADDR_WIDTH-1:0] rob_train_pc_in,
    input  logic                  rob_train_taken_in,
    output logic                  rob_train_ready_out,
    output logic                  init_busy_out
);

    localparam int unsigned DEPTH = 1 << INDEX_BITS;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [INDEX_BITS-1:0] idx;
        logic                  taken;
    } train_entry_t;

    logic [0:0]            state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;

    logic [1:0]            table_mem [DEPTH];
    train_entry_t          fifo_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  upd_pending_q;
    logic [INDEX_BITS-1:0] upd_idx_q;
    logic                  upd_taken_q;
    logic [1:0]            upd_ctr_q;
    logic [1:0]            upd_next;

    logic                  pred_valid_q, pred_taken_q;

    logic                  fifo_full, fifo_empty, enq, pop;
    train_entry_t          head;
    logic [INDEX_BITS-1:0] dec_idx, train_idx;

    logic                  grant_wr, grant_rd, grant_lk;
    logic                  tbl_we;
    logic [INDEX_BITS-1:0] tbl_addr;
    logic [1:0]            tbl_wdata, tbl_rdata;

    logic                  unused_pc_bits;

    assign dec_idx    = dec_pc_in[INDEX_BITS+1:2];
    assign train_idx  = rob_train_pc_in[INDEX_BITS+1:2];
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_mem[rd_ptr_q];
    assign tbl_rdata  = table_mem[tbl_addr];

    assign rob_train_ready_out = rdy_in && !fifo_full;
    assign enq                 = rob_train_en_in && rob_train_ready_out;
    assign pop                 = grant_rd;

    assign dec_ready_out  = grant_lk;
    assign pred_valid_out = pred_valid_q && rdy_in;
    assign pred_taken_out = pred_taken_q;
    assign init_busy_out  = (state_q == ST_INIT);

    assign unused_pc_bits = ^{dec_pc_in[ADDR_WIDTH-1:INDEX_BITS+2], dec_pc_in[1:0],
                              rob_train_pc_in[ADDR_WIDTH-1:INDEX_BITS+2], rob_train_pc_in[1:0]};

    // Saturating 2-bit counter step for the pending update
    always_comb begin
        upd_next = upd_ctr_q;
        if (upd_taken_q) begin
            if (upd_ctr_q != 2'b11) upd_next = upd_ctr_q + 2'b01;
        end else begin
            if (upd_ctr_q != 2'b00) upd_next = upd_ctr_q - 2'b01;
        end
    end

    // Next state and single-port arbitration; the pending write always wins so an
    // update's read/write pair is back to back and lookups only see committed data.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        grant_lk   = 1'b0;
        tbl_we     = 1'b0;
        tbl_addr   = dec_idx;
        tbl_wdata  = INIT_STATE;
        if (rdy_in) begin
            case (state_q)
                ST_INIT: begin
                    tbl_we     = 1'b1;
                    tbl_addr   = init_idx_q;
                    tbl_wdata  = INIT_STATE;
                    init_idx_d = init_idx_q + INDEX_BITS'(1);
                    if (init_idx_q == INDEX_BITS'(DEPTH - 1)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (upd_pending_q) begin
                        grant_wr  = 1'b1;
                        tbl_we    = 1'b1;
                        tbl_addr  = upd_idx_q;
                        tbl_wdata = upd_next;
                    end else if (fifo_full) begin
                        grant_rd = 1'b1;
                        tbl_addr = head.idx;
                    end else if (dec_req_in) begin
                        grant_lk = 1'b1;
                        tbl_addr = dec_idx;
                    end else if (!fifo_empty) begin
                        grant_rd = 1'b1;
                        tbl_addr = head.idx;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // FIFO pointers, update latch and prediction registers
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            upd_pending_q <= 1'b0;
            upd_idx_q     <= '0;
            upd_taken_q   <= 1'b0;
            upd_ctr_q     <= 2'b00;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
        end else begin
            pred_valid_q <= grant_lk;
            if (grant_lk) pred_taken_q <= tbl_rdata[1];
            if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (enq && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !enq) count_q <= count_q - CNT_W'(1);
            if (grant_rd) begin
                upd_pending_q <= 1'b1;
                upd_idx_q     <= head.idx;
                upd_taken_q   <= head.taken;
                upd_ctr_q     <= tbl_rdata;
            end else if (grant_wr) begin
                upd_pending_q <= 1'b0;
            end
        end
    end

    // Storage arrays carry no reset; the sweep defines table contents
    always_ff @(posedge clk_in) begin
        if (rst_in && enq) fifo_mem[wr_ptr_q] <= '{idx: train_idx, taken: rob_train_taken_in};
        if (rst_in && tbl_we) table_mem[tbl_addr] <= tbl_wdata;
    end

endmodule
